// File: rtl/keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
//
// Scanning controller for a 4x4 matrix keypad. One column is driven low at a
// time. The active-low rows are brought into the clock domain by a two-flop
// synchronizer. A press is accepted only after it has been stable for
// DEBOUNCE_CYCLES cycles. The release must also be stable for that long before
// scanning resumes. Each physical keypress produces exactly one pulse_en
// strobe, and the decoded hex digit is presented on key_pushed.
//
// Parameters
//   SCAN_DIV         cycles each column is driven before advancing (>= 4)
//   DEBOUNCE_CYCLES  consecutive stable cycles to accept press/release (>= 2)
//
// Ports
//   clk         in   1  system clock
//   rst         in   1  synchronous, active-high reset
//   row         in   4  keypad rows, active-low, asynchronous to clk
//   col         out  4  keypad columns, exactly one bit low at all times
//   pulse_en    out  1  one-cycle strobe for a newly accepted key
//   key_pushed  out  4  hex value of the last accepted key, held between strobes
// -----------------------------------------------------------------------------
module keypad_scan_ctrl #(
   parameter int SCAN_DIV        = 50000,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic       pulse_en,
   output logic [3:0] key_pushed
);

   localparam int DWELL_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int DEB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
   localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
   localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DEB_W-1:0]   DEB_ONE    = DEB_W'(1);

   localparam logic [1:0] ST_SCAN      = 2'd0;
   localparam logic [1:0] ST_DEB_PRESS = 2'd1;
   localparam logic [1:0] ST_HOLD      = 2'd2;
   localparam logic [1:0] ST_DEB_REL   = 2'd3;

   localparam logic [3:0] COL_FIRST = 4'b1110;
   localparam logic [3:0] ROWS_IDLE = 4'b1111;

   // ------------------------------------------------------------------
   // Row synchronizer: two flops per row bit. Both stages reset to the
   // idle (all high) level so a reset never looks like a keypress.
   // ------------------------------------------------------------------
   logic [3:0] row_s;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sync
         logic meta_reg;
         logic sync_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               meta_reg <= 1'b1;
               sync_reg <= 1'b1;
            end else begin
               meta_reg <= row[gi];
               sync_reg <= meta_reg;
            end
         end

         assign row_s[gi] = sync_reg;
      end
   endgenerate

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   logic [1:0]         state_reg,      state_next;
   logic [3:0]         col_reg,        col_next;
   logic [DWELL_W-1:0] dwell_reg,      dwell_next;
   logic [DEB_W-1:0]   deb_reg,        deb_next;
   logic [1:0]         row_idx_reg,    row_idx_next;
   logic [1:0]         col_idx_reg,    col_idx_next;
   logic               pulse_reg,      pulse_next;
   logic [3:0]         key_reg,        key_next;

   // ------------------------------------------------------------------
   // Row decode helpers
   // ------------------------------------------------------------------
   logic [3:0] row_low;
   logic       one_low;
   logic [1:0] row_enc;
   logic [1:0] col_enc;
   logic [3:0] col_rot;
   logic [3:0] held_pattern;

   assign row_low = ~row_s;
   // Exactly one bit set: non-zero, and clearing the lowest set bit leaves
   // nothing. Zero or several lows (ghosting or multi-key) are rejected.
   assign one_low = (row_low != 4'd0) && ((row_low & (row_low - 4'd1)) == 4'd0);

   always_comb begin
      row_enc = 2'd0;
      case (row_low)
         4'b0001: row_enc = 2'd0;
         4'b0010: row_enc = 2'd1;
         4'b0100: row_enc = 2'd2;
         4'b1000: row_enc = 2'd3;
         default: row_enc = 2'd0;
      endcase
   end

   always_comb begin
      col_enc = 2'd0;
      case (col_reg)
         4'b1110: col_enc = 2'd0;
         4'b1101: col_enc = 2'd1;
         4'b1011: col_enc = 2'd2;
         4'b0111: col_enc = 2'd3;
         default: col_enc = 2'd0;
      endcase
   end

   // Rotate left so the single low bit walks col0 -> col1 -> col2 -> col3.
   assign col_rot = {col_reg[2:0], col_reg[3]};

   // The one-hot-low row pattern that the latched key produces.
   assign held_pattern = ~(4'b0001 << row_idx_reg);

   // Keypad legend, indexed by {row, col}.
   function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] value;
      case ({r, c})
         4'd0:    value = 4'h1;
         4'd1:    value = 4'h2;
         4'd2:    value = 4'h3;
         4'd3:    value = 4'hA;
         4'd4:    value = 4'h4;
         4'd5:    value = 4'h5;
         4'd6:    value = 4'h6;
         4'd7:    value = 4'hB;
         4'd8:    value = 4'h7;
         4'd9:    value = 4'h8;
         4'd10:   value = 4'h9;
         4'd11:   value = 4'hC;
         4'd12:   value = 4'hE;
         4'd13:   value = 4'h0;
         4'd14:   value = 4'hF;
         default: value = 4'hD;
      endcase
      return value;
   endfunction

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next   = state_reg;
      col_next     = col_reg;
      dwell_next   = dwell_reg;
      deb_next     = deb_reg;
      row_idx_next = row_idx_reg;
      col_idx_next = col_idx_reg;
      pulse_next   = 1'b0;
      key_next     = key_reg;

      case (state_reg)
         ST_SCAN: begin
            if (dwell_reg == DWELL_LAST) begin
               // Rows are only looked at on the last dwell cycle, which gives
               // the column line and the synchronizer time to settle.
               dwell_next = '0;
               if (one_low) begin
                  row_idx_next = row_enc;
                  col_idx_next = col_enc;
                  deb_next     = '0;
                  state_next   = ST_DEB_PRESS;
               end else begin
                  col_next = col_rot;
               end
            end else begin
               dwell_next = dwell_reg + DWELL_ONE;
            end
         end

         ST_DEB_PRESS: begin
            if (row_s == held_pattern) begin
               if (deb_reg == DEB_LAST) begin
                  key_next   = keymap(row_idx_reg, col_idx_reg);
                  pulse_next = 1'b1;
                  deb_next   = '0;
                  state_next = ST_HOLD;
               end else begin
                  deb_next = deb_reg + DEB_ONE;
               end
            end else begin
               // Bounce: give up and re-sample the same column after a full
               // dwell period.
               dwell_next = '0;
               state_next = ST_SCAN;
            end
         end

         ST_HOLD: begin
            // Other keys pressed while one is held are ignored here. The
            // column stays frozen, so only keys in this column are visible.
            if (row_s == ROWS_IDLE) begin
               deb_next   = '0;
               state_next = ST_DEB_REL;
            end
         end

         ST_DEB_REL: begin
            if (row_s == ROWS_IDLE) begin
               if (deb_reg == DEB_LAST) begin
                  col_next   = col_rot;
                  dwell_next = '0;
                  deb_next   = '0;
                  state_next = ST_SCAN;
               end else begin
                  deb_next = deb_reg + DEB_ONE;
               end
            end else begin
               state_next = ST_HOLD;
            end
         end

         default: begin
            state_next = ST_SCAN;
            col_next   = COL_FIRST;
            dwell_next = '0;
            deb_next   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_SCAN;
         col_reg     <= COL_FIRST;
         dwell_reg   <= '0;
         deb_reg     <= '0;
         row_idx_reg <= 2'd0;
         col_idx_reg <= 2'd0;
         pulse_reg   <= 1'b0;
         key_reg     <= 4'h0;
      end else begin
         state_reg   <= state_next;
         col_reg     <= col_next;
         dwell_reg   <= dwell_next;
         deb_reg     <= deb_next;
         row_idx_reg <= row_idx_next;
         col_idx_reg <= col_idx_next;
         pulse_reg   <= pulse_next;
         key_reg     <= key_next;
      end
   end

   assign col        = col_reg;
   assign pulse_en   = pulse_reg;
   assign key_pushed = key_reg;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan_ctrl
//
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4 and DEBOUNCE_CYCLES=8.
// A keypad model pulls a row low when a pressed key sits in the currently
// driven column. Inputs change on the falling clock edge, and outputs are
// sampled there too.
// -----------------------------------------------------------------------------
module tb_keypad_scan_ctrl;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 8;

   // Key positions in the pressed mask: bit index = row*4 + col.
   localparam logic [15:0] K1 = 16'h0001 << 0;
   localparam logic [15:0] K3 = 16'h0001 << 2;
   localparam logic [15:0] KA = 16'h0001 << 3;
   localparam logic [15:0] K4 = 16'h0001 << 4;
   localparam logic [15:0] K5 = 16'h0001 << 5;
   localparam logic [15:0] K6 = 16'h0001 << 6;
   localparam logic [15:0] K9 = 16'h0001 << 10;
   localparam logic [15:0] K0 = 16'h0001 << 13;
   localparam logic [15:0] KF = 16'h0001 << 14;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        pulse_en;
   logic [3:0]  key_pushed;
   logic [15:0] pressed;

   int checks     = 0;
   int failures   = 0;
   int strobe_cnt = 0;

   always #5 clk = ~clk;

   keypad_scan_ctrl #(
      .SCAN_DIV        (SCAN_DIV),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .row        (row),
      .col        (col),
      .pulse_en   (pulse_en),
      .key_pushed (key_pushed)
   );

   // Keypad model: a pressed key shorts its row to its column when that column is driven low.
   always_comb begin
      row = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4 + c] && (col[c] == 1'b0)) row[r] = 1'b0;
         end
      end
   end

   // Strobe log: one line per accepted key.
   always @(posedge clk) begin
      if (pulse_en === 1'b1) begin
         strobe_cnt = strobe_cnt + 1;
         $display("strobe #%0d key_pushed=%h at %0t", strobe_cnt, key_pushed, $time);
      end
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #100000;
      $display("FAIL watchdog expired: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_pulse(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (pulse_en === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      rst     = 1'b1;
      pressed = 16'h0;
      tick(3);
      checks++;
      if (col !== 4'b1110) begin failures++; $display("FAIL reset_col got=%b exp=1110", col); end
      checks++;
      if (pulse_en !== 1'b0) begin failures++; $display("FAIL reset_pulse got=%b exp=0", pulse_en); end
      checks++;
      if (key_pushed !== 4'h0) begin failures++; $display("FAIL reset_key got=%h exp=0", key_pushed); end
      rst = 1'b0;
      tick(3);
      checks++;
      if (col !== 4'b1110) begin failures++; $display("FAIL scan_dwell0 got=%b exp=1110", col); end
      tick(1);
      checks++;
      if (col !== 4'b1101) begin failures++; $display("FAIL scan_step1 got=%b exp=1101", col); end
      tick(4);
      checks++;
      if (col !== 4'b1011) begin failures++; $display("FAIL scan_step2 got=%b exp=1011", col); end
      tick(4);
      checks++;
      if (col !== 4'b0111) begin failures++; $display("FAIL scan_step3 got=%b exp=0111", col); end
      $display("test_reset done");
   endtask

   // Starts right after test_reset: col just became 0111 with dwell 0.
   // Column 2 comes up 12 cycles later, the sample lands 4 cycles after that,
   // and the strobe follows DEB cycles later: 24 cycles from now.
   task automatic test_clean_press();
      int base;
      base    = strobe_cnt;
      pressed = K6;
      tick(23);
      checks++;
      if (pulse_en !== 1'b0) begin failures++; $display("FAIL press6_early got=%b exp=0", pulse_en); end
      checks++;
      if (col !== 4'b1011) begin failures++; $display("FAIL press6_frozen got=%b exp=1011", col); end
      tick(1);
      checks++;
      if (pulse_en !== 1'b1) begin failures++; $display("FAIL press6_pulse got=%b exp=1", pulse_en); end
      checks++;
      if (key_pushed !== 4'h6) begin failures++; $display("FAIL press6_key got=%h exp=6", key_pushed); end
      tick(1);
      checks++;
      if (pulse_en !== 1'b0) begin failures++; $display("FAIL press6_one_cycle got=%b exp=0", pulse_en); end
      tick(75);
      checks++;
      if (strobe_cnt - base !== 1) begin failures++; $display("FAIL press6_count got=%0d exp=1", strobe_cnt - base); end
      checks++;
      if (col !== 4'b1011) begin failures++; $display("FAIL press6_held_col got=%b exp=1011", col); end
      // Release: 2 sync + 1 to leave HOLD + DEB stable cycles = 11 cycles.
      pressed = 16'h0;
      tick(10);
      checks++;
      if (col !== 4'b1011) begin failures++; $display("FAIL rel6_still_frozen got=%b exp=1011", col); end
      tick(1);
      checks++;
      if (col !== 4'b0111) begin failures++; $display("FAIL rel6_resume got=%b exp=0111", col); end
      $display("test_clean_press done");
   endtask

   task automatic test_bounce();
      int  base;
      bit  seen;
      base = strobe_cnt;
      for (int i = 0; i < 5; i++) begin
         pressed = KA;
         tick(3);
         pressed = 16'h0;
         tick(3);
      end
      checks++;
      if (strobe_cnt - base !== 0) begin failures++; $display("FAIL bounce_no_strobe got=%0d exp=0", strobe_cnt - base); end
      pressed = KA;
      wait_pulse(60, seen);
      checks++;
      if (seen !== 1'b1) begin failures++; $display("FAIL bounce_stable_pulse got=%b exp=1", seen); end
      checks++;
      if (key_pushed !== 4'hA) begin failures++; $display("FAIL bounce_key got=%h exp=a", key_pushed); end
      pressed = 16'h0;
      tick(20);
      checks++;
      if (strobe_cnt - base !== 1) begin failures++; $display("FAIL bounce_count got=%0d exp=1", strobe_cnt - base); end
      $display("test_bounce done");
   endtask

   task automatic test_back_to_back();
      logic [15:0] keys [3];
      logic [3:0]  vals [3];
      int          base;
      bit          seen;
      keys[0] = K4; vals[0] = 4'h4;
      keys[1] = K0; vals[1] = 4'h0;
      keys[2] = KF; vals[2] = 4'hF;
      base = strobe_cnt;
      for (int k = 0; k < 3; k++) begin
         pressed = keys[k];
         wait_pulse(60, seen);
         checks++;
         if (seen !== 1'b1) begin failures++; $display("FAIL seq%0d_pulse got=%b exp=1", k, seen); end
         checks++;
         if (key_pushed !== vals[k]) begin failures++; $display("FAIL seq%0d_key got=%h exp=%h", k, key_pushed, vals[k]); end
         if (k < 2) begin
            pressed = 16'h0;
            tick(20);
         end
      end
      tick(10);
      pressed = 16'h0;
      tick(20);
      checks++;
      if (key_pushed !== 4'hF) begin failures++; $display("FAIL seq_hold_key got=%h exp=f", key_pushed); end
      checks++;
      if (strobe_cnt - base !== 3) begin failures++; $display("FAIL seq_count got=%0d exp=3", strobe_cnt - base); end
      $display("test_back_to_back done");
   endtask

   task automatic test_extra_key();
      int base;
      bit seen;
      base    = strobe_cnt;
      pressed = K5;
      wait_pulse(60, seen);
      checks++;
      if (seen !== 1'b1) begin failures++; $display("FAIL extra_first_pulse got=%b exp=1", seen); end
      checks++;
      if (key_pushed !== 4'h5) begin failures++; $display("FAIL extra_first_key got=%h exp=5", key_pushed); end
      pressed = K5 | K9;
      tick(40);
      checks++;
      if (strobe_cnt - base !== 1) begin failures++; $display("FAIL extra_no_second got=%0d exp=1", strobe_cnt - base); end
      pressed = 16'h0;
      tick(10);
      checks++;
      if (col !== 4'b1101) begin failures++; $display("FAIL extra_rel_frozen got=%b exp=1101", col); end
      tick(1);
      checks++;
      if (col !== 4'b1011) begin failures++; $display("FAIL extra_rel_resume got=%b exp=1011", col); end
      tick(20);
      checks++;
      if (strobe_cnt - base !== 1) begin failures++; $display("FAIL extra_final_count got=%0d exp=1", strobe_cnt - base); end
      $display("test_extra_key done");
   endtask

   task automatic test_multi_key();
      int base;
      base    = strobe_cnt;
      pressed = K1 | K4;   // same column, two rows
      tick(40);
      checks++;
      if (strobe_cnt - base !== 0) begin failures++; $display("FAIL multi_rejected got=%0d exp=0", strobe_cnt - base); end
      pressed = 16'h0;
      tick(5);
      $display("test_multi_key done");
   endtask

   // After reset release, column 2 is driven 8 cycles later, DEB_PRESS is entered 4 later,
   // and the strobe follows DEB cycles later. Reset hits 3 cycles into DEB_PRESS.
   task automatic test_reset_mid_press();
      int base;
      base = strobe_cnt;
      rst  = 1'b1;
      tick(2);
      pressed = K3;
      rst     = 1'b0;
      tick(15);
      rst = 1'b1;
      tick(2);
      checks++;
      if (col !== 4'b1110) begin failures++; $display("FAIL midrst_col got=%b exp=1110", col); end
      checks++;
      if (pulse_en !== 1'b0) begin failures++; $display("FAIL midrst_pulse got=%b exp=0", pulse_en); end
      checks++;
      if (key_pushed !== 4'h0) begin failures++; $display("FAIL midrst_key got=%h exp=0", key_pushed); end
      rst = 1'b0;
      tick(19);
      checks++;
      if (pulse_en !== 1'b0) begin failures++; $display("FAIL midrst_early got=%b exp=0", pulse_en); end
      tick(1);
      checks++;
      if (pulse_en !== 1'b1) begin failures++; $display("FAIL midrst_pulse_after got=%b exp=1", pulse_en); end
      checks++;
      if (key_pushed !== 4'h3) begin failures++; $display("FAIL midrst_key_after got=%h exp=3", key_pushed); end
      tick(30);
      checks++;
      if (strobe_cnt - base !== 1) begin failures++; $display("FAIL midrst_count got=%0d exp=1", strobe_cnt - base); end
      pressed = 16'h0;
      tick(20);
      $display("test_reset_mid_press done");
   endtask

   initial begin
      rst     = 1'b1;
      pressed = 16'h0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_back_to_back();
      test_extra_key();
      test_multi_key();
      test_reset_mid_press();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scanning controller for the 4x4 matrix keypad. It drives one column low at a time and reads the active-low rows through a two-flop synchronizer. It debounces press and release, and issues exactly one `pulse_en` strobe with the decoded hex digit on `key_pushed` per physical keypress. It sits between the keypad pins and `slide_state`, and is the only source of that block's `pulse_en`/`key_pushed` inputs.

## Interface

**Parameters**
- `SCAN_DIV`, default 50000: clock cycles each column is driven before advancing; must be ≥ 4.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a press or a release; must be ≥ 2.

**Ports**
- `clk`  input  1: system clock, single clock domain.
- `rst`  input  1: reset, synchronous and active-high.
- `row`  input  4: keypad rows, active-low (pulled up), asynchronous.
- `col`  output  4: keypad columns; exactly one bit low at all times.
- `pulse_en`  output  1: one-cycle strobe, high when `key_pushed` holds a newly accepted key.
- `key_pushed`  output  4: hex value of the last accepted key; holds between strobes.

## Operation

**Synchronizer**
- `row` passes through 2 flops, producing `row_s`.
- All decisions use `row_s`.
- Synchronizer flops reset to `4'b1111`.

**Keymap**, listed as (row, col) → value, with index 0 the LSB:
- Row 0: col0 = 1, col1 = 2, col2 = 3, col3 = A.
- Row 1: col0 = 4, col1 = 5, col2 = 6, col3 = B.
- Row 2: col0 = 7, col1 = 8, col2 = 9, col3 = C.
- Row 3: col0 = E, col1 = 0, col2 = F, col3 = D.

**States** (one-hot or encoded, implementer's choice):
- **SCAN**
  - `col` rotates: `1110`→`1101`→`1011`→`0111`→`1110`. It advances when the dwell counter reaches `SCAN_DIV-1`.
  - `row_s` is sampled on the final dwell cycle only.
  - If exactly one `row_s` bit is low: latch row index and column index, freeze `col`, clear the debounce counter, go to DEB_PRESS.
  - If zero or ≥ 2 bits are low: ignore and advance the column.
- **DEB_PRESS**
  - `col` stays frozen.
  - Each cycle that `row_s` equals the latched one-hot-low pattern, increment the counter.
  - Any mismatch returns to SCAN with the dwell counter cleared, staying on the same column.
  - When the counter reaches `DEBOUNCE_CYCLES-1`:
    - load `key_pushed` from the keymap;
    - assert `pulse_en` for one cycle;
    - go to HOLD.
- **HOLD**
  - `col` stays frozen; no further strobes.
  - When `row_s == 4'b1111`: clear the counter and go to DEB_REL.
  - Additional keys pressed meanwhile are ignored.
- **DEB_REL**
  - Each all-high cycle increments the counter.
  - Any low bit returns to HOLD, with no strobe.
  - When the counter reaches `DEBOUNCE_CYCLES-1`: go to SCAN at the next column with the dwell counter cleared.

**Boundary conditions**
- A key held for any duration produces exactly one strobe.
- Bounce shorter than `DEBOUNCE_CYCLES` never produces a strobe.
- Multi-key in the same column at the sample point: not accepted.
- `rst` asserted in any state: the next edge restores reset values and any pending strobe is discarded.

## Timing

**Reset values** (on the `clk` edge with `rst`=1):
- `col` = `4'b1110`
- `pulse_en` = 0
- `key_pushed` = `4'h0`
- state = SCAN
- dwell counter and debounce counter = 0

**Latency**
- Pin to `row_s`: 2 cycles.
- Sample to DEB_PRESS entry: 1 cycle.
- `pulse_en` is registered. It is high during the cycle after the counter reaches `DEBOUNCE_CYCLES-1`, i.e. `DEBOUNCE_CYCLES` stable cycles after DEB_PRESS entry.
- `key_pushed` updates on the same edge that `pulse_en` rises, and is stable while `pulse_en` is high.

**Scan rate and minimum repeat**
- Column period is `4*SCAN_DIV` cycles.
- Minimum time between strobes is `2*DEBOUNCE_CYCLES` + scan time.

**Output registration**
- All outputs come directly from flops, so there are no combinational paths from `row` to the outputs.

## Test plan

All scenarios use `SCAN_DIV`=4, `DEBOUNCE_CYCLES`=8, with a keypad model that drives `row` from `col` and the pressed-key set.

1. **Reset behaviour.** Hold `rst`=1 for 3 cycles with no key pressed → `col`=`1110`, `pulse_en`=0, `key_pushed`=0. Then release `rst` → `col` steps through `1101`, `1011`, `0111`, one step every 4 cycles.
2. **Clean press.** Press key "6" (row 1, col 2) and hold 100 cycles → exactly one `pulse_en` cycle with `key_pushed`=`4'h6`, and `col` frozen at `1011` while held. On release, scanning resumes at `0111` after 8 stable-high cycles.
3. **Bounce rejection.** Press "A" with 3-cycle on/off chatter for 30 cycles → no strobe. Then hold "A" stable → one strobe with `key_pushed`=`4'hA`.
4. **Sequence feeding `slide_state`.** Press "4", release, press "0", release, press "F" → three strobes carrying `4'h4`, `4'h0`, `4'hF` in order. `key_pushed` holds `4'hF` afterwards.
5. **Extra key while held.** Hold "5", then also press "9" → no second strobe. Release both → no strobe. Release debounce completes, then scanning resumes.
6. **Reset mid-press.** Assert `rst` during DEB_PRESS on "3" → no strobe and the reset values are restored. After `rst` deasserts with "3" still held → one strobe with `key_pushed`=`4'h3`.
